vector_store_serializer: RTL and testbench
==========================================

Name: vector_store_serializer

Overview:
Write-side counterpart of the ID-stage vector data mux. It accepts one 8-lane vector (8 x 32-bit words) in parallel and serializes it onto the single-word data-memory write port, one lane per accepted beat. Lanes go out in order from lane1 to lane8, and a per-lane mask can skip any lane. It sits between the vector register read path and data memory, and executes vector store instructions.

Parameters:
DATA_WIDTH, 32, width of each lane and of mem_wdata
ADDR_WIDTH, 32, width of base_addr and mem_addr
ADDR_STEP, 4, byte increment between consecutive lane addresses

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to store; sampled only while busy=0
base_addr  input  ADDR_WIDTH  address of lane1
lane_mask  input  8  bit k-1 enables lane k
lane1..lane8  input  DATA_WIDTH each  vector lanes to store
mem_ready  input  1  memory accepts the current beat at this edge
mem_we  output  1  write beat valid
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  DATA_WIDTH  write data
busy  output  1  operation in progress; start is ignored
done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - On rst=1 at an edge: state goes to IDLE.
  - mem_we, busy and done become 0; mem_addr and mem_wdata become 0.
  - Captured lane, base and mask registers are cleared.
  - Reset takes priority over start and mem_ready. An in-flight store is abandoned; no further beats are issued.
- States: IDLE, SEND, DONE.
- IDLE:
  - busy=0, mem_we=0.
  - If start=1 at an edge, capture lane1..lane8, base_addr and lane_mask into internal registers.
  - If the captured mask is nonzero, go to SEND with idx = lowest set mask bit.
  - If the captured mask is 0, go to DONE directly.
  - After capture, later changes to the inputs have no effect on the operation.
- SEND:
  - busy=1, mem_we=1.
  - mem_addr = captured_base + idx*ADDR_STEP, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - mem_wdata = captured lane(idx+1).
  - Outputs are decoded from registered state only; no combinational path from any input to any output.
  - If mem_ready=0 at an edge: hold idx; mem_we, mem_addr and mem_wdata stay stable.
  - If mem_ready=1 at an edge: the beat is accepted; idx advances to the next higher set mask bit. If no higher bit is set, go to DONE.
- DONE:
  - busy=1, mem_we=0, done=1 for exactly one cycle, then go to IDLE.
  - start asserted during DONE is ignored.
- Outside SEND, mem_addr and mem_wdata hold their last value (0 after reset). They are don't-care when mem_we=0.
- Timing (start sampled at edge 0, mask=8'hFF, mem_ready held 1):
  - beats in cycles 1..8
  - done=1 in cycle 9
  - busy=1 in cycles 1..9
  - earliest next start sampled at the end of cycle 10
- Total cycles for a store = popcount(mask) + number of stall cycles + 1.
- start held high continuously: a new store is captured each time the block returns to IDLE.

Test Plan:
1. lane k = k, base=0x100, mask=8'hFF, mem_ready=1 -> beats (0x100,1),(0x104,2)...(0x11C,8) in cycles 1..8; done pulse in cycle 9 only; busy=0 in cycle 10.
2. Same lanes, mask=8'hA5 -> exactly 4 beats: (0x100,1),(0x108,3),(0x114,6),(0x11C,8); then done.
3. mask=8'hFF, mem_ready=0 in cycles 2-4 -> beat (0x104,2) held stable for 4 cycles; all 8 beats delivered in order; done in cycle 12.
4. mask=8'h00 -> no mem_we ever; done=1 in cycle 1; busy=1 only in cycle 1.
5. base=0xFFFFFFF8, mask=8'h0F -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
6. Two disturbances during the store in scenario 1:
   - lanes changed to 99 and start pulsed in cycle 3 -> still data 1..8; no second store.
   - rst=1 at the edge ending cycle 4 -> mem_we=0, busy=0, done=0 from cycle 5 on; no done pulse.

Source files
------------

// File: rtl/vector_store_serializer.sv
// vector_store_serializer
// Captures one 8-lane vector and writes it to data memory one lane per
// accepted beat, lowest lane first, skipping lanes whose mask bit is clear.
// All outputs come from registers, so no input reaches an output in the
// same cycle.
module vector_store_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            lane_mask,
  input  logic [DATA_WIDTH-1:0] lane1,
  input  logic [DATA_WIDTH-1:0] lane2,
  input  logic [DATA_WIDTH-1:0] lane3,
  input  logic [DATA_WIDTH-1:0] lane4,
  input  logic [DATA_WIDTH-1:0] lane5,
  input  logic [DATA_WIDTH-1:0] lane6,
  input  logic [DATA_WIDTH-1:0] lane7,
  input  logic [DATA_WIDTH-1:0] lane8,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [7:0]            mask_q, mask_d;
  logic [DATA_WIDTH-1:0] lane_q [8];
  logic [DATA_WIDTH-1:0] lane_d [8];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] lane_in [8];
  logic [3:0]            nxt;

  // Lowest set bit of m at position >= from; result is {found, index}.
  // A start position of 8 or more finds nothing.
  function automatic logic [3:0] find_set(input logic [7:0] m,
                                          input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      if (k >= int'(from) && m[k]) begin
        r = {1'b1, 3'(k)};
      end
    end
    return r;
  endfunction

  // Byte address of a lane; the sum wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] lane_addr(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [2:0]            idx);
    logic [ADDR_WIDTH-1:0] off;
    off = ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STEP);
    return base + off;
  endfunction

  // Gather the discrete lane ports into an indexable array.
  always_comb begin
    lane_in[0] = lane1;
    lane_in[1] = lane2;
    lane_in[2] = lane3;
    lane_in[3] = lane4;
    lane_in[4] = lane5;
    lane_in[5] = lane6;
    lane_in[6] = lane7;
    lane_in[7] = lane8;
  end

  // Next-state logic: capture on start, step through set mask bits on
  // accepted beats, and pre-compute the next beat's address and data.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nxt     = 4'b0000;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr;
          mask_d = lane_mask;
          lane_d = lane_in;
          nxt    = find_set(lane_mask, 4'd0);
          if (nxt[3]) begin
            state_d = SEND;
            idx_d   = nxt[2:0];
            addr_d  = lane_addr(base_addr, nxt[2:0]);
            wdata_d = lane_in[nxt[2:0]];
          end else begin
            // Empty mask: nothing to write, just report completion.
            state_d = DONE;
          end
        end
      end

      SEND: begin
        // Without mem_ready everything holds so the beat stays stable.
        if (mem_ready) begin
          nxt = find_set(mask_q, {1'b0, idx_q} + 4'd1);
          if (nxt[3]) begin
            idx_d   = nxt[2:0];
            addr_d  = lane_addr(base_q, nxt[2:0]);
            wdata_d = lane_q[nxt[2:0]];
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers; reset abandons any store in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      base_q  <= '0;
      mask_q  <= 8'h00;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int k = 0; k < 8; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int k = 0; k < 8; k++) begin
        lane_q[k] <= lane_d[k];
      end
    end
  end

  assign mem_we    = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench for vector_store_serializer. Cycle n is the interval after
// clock edge n, where edge 0 samples start. Outputs are checked 1 ns after
// each rising edge; inputs are changed at the same point.
module tb_vector_store_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  lane_mask;
  logic [31:0] lane1, lane2, lane3, lane4, lane5, lane6, lane7, lane8;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  vector_store_serializer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .ADDR_STEP (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .lane_mask(lane_mask),
    .lane1    (lane1),
    .lane2    (lane2),
    .lane3    (lane3),
    .lane4    (lane4),
    .lane5    (lane5),
    .lane6    (lane6),
    .lane7    (lane7),
    .lane8    (lane8),
    .mem_ready(mem_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a,
                          input logic [31:0] d);
    chk({tag, " we"},    32'(mem_we),  32'd1);
    chk({tag, " addr"},  mem_addr,     a);
    chk({tag, " data"},  mem_wdata,    d);
    chk({tag, " busy"},  32'(busy),    32'd1);
    chk({tag, " done"},  32'(done),    32'd0);
  endtask

  task automatic chk_ctl(input string tag, input logic we, input logic bz,
                         input logic dn);
    chk({tag, " we"},   32'(mem_we), 32'(we));
    chk({tag, " busy"}, 32'(busy),   32'(bz));
    chk({tag, " done"}, 32'(done),   32'(dn));
  endtask

  task automatic lanes_seq();
    lane1 = 32'd1; lane2 = 32'd2; lane3 = 32'd3; lane4 = 32'd4;
    lane5 = 32'd5; lane6 = 32'd6; lane7 = 32'd7; lane8 = 32'd8;
  endtask

  task automatic lanes_all(input logic [31:0] v);
    lane1 = v; lane2 = v; lane3 = v; lane4 = v;
    lane5 = v; lane6 = v; lane7 = v; lane8 = v;
  endtask

  initial begin
    int a5_idx [4];
    a5_idx = '{0, 2, 5, 7};

    rst = 1'b1; start = 1'b0; base_addr = 32'h0; lane_mask = 8'h00;
    mem_ready = 1'b1;
    lanes_all(32'hDEAD_BEEF);
    tick();
    start = 1'b1;  // must be ignored during reset
    tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset addr", mem_addr,  32'h0);
    chk("reset data", mem_wdata, 32'h0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk_ctl("post-reset idle", 1'b0, 1'b0, 1'b0);

    // 1: full mask, no stalls
    lanes_seq(); base_addr = 32'h100; lane_mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk_beat($sformatf("t1 c%0d", c), 32'h100 + 32'(4 * (c - 1)), 32'(c));
      tick();
    end
    chk_ctl("t1 c9", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t1 c10", 1'b0, 1'b0, 1'b0);

    // 2: sparse mask 8'hA5
    lane_mask = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_beat($sformatf("t2 c%0d", c), 32'h100 + 32'(4 * a5_idx[c - 1]),
               32'(a5_idx[c - 1] + 1));
      tick();
    end
    chk_ctl("t2 c5", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t2 c6", 1'b0, 1'b0, 1'b0);

    // 3: mem_ready low in cycles 2-4 holds lane 2 for cycles 2..5
    lane_mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      int ln;
      ln = (c == 1) ? 1 : (c <= 5) ? 2 : c - 3;
      chk_beat($sformatf("t3 c%0d", c), 32'h100 + 32'(4 * (ln - 1)), 32'(ln));
      mem_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      tick();
    end
    chk_ctl("t3 c12", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t3 c13", 1'b0, 1'b0, 1'b0);

    // 4: empty mask goes straight to completion
    lane_mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk_ctl("t4 c1", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t4 c2", 1'b0, 1'b0, 1'b0);

    // 5: address wrap
    base_addr = 32'hFFFF_FFF8; lane_mask = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("t5 c1", 32'hFFFF_FFF8, 32'd1);
    tick();
    chk_beat("t5 c2", 32'hFFFF_FFFC, 32'd2);
    tick();
    chk_beat("t5 c3", 32'h0000_0000, 32'd3);
    tick();
    chk_beat("t5 c4", 32'h0000_0004, 32'd4);
    tick();
    chk_ctl("t5 c5", 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("t5 c6", 1'b0, 1'b0, 1'b0);

    // 6: input changes and start mid-store are ignored; reset aborts
    base_addr = 32'h100; lane_mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("t6 c1", 32'h100, 32'd1);
    tick();
    chk_beat("t6 c2", 32'h104, 32'd2);
    tick();
    chk_beat("t6 c3", 32'h108, 32'd3);
    lanes_all(32'd99); start = 1'b1; base_addr = 32'h500;
    tick();
    chk_beat("t6 c4", 32'h10C, 32'd4);
    start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 5; c <= 14; c++) begin
      chk_ctl($sformatf("t6 c%0d", c), 1'b0, 1'b0, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
